// File: rtl/cache_pkg.sv
// Shared types and parameter helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_SET_BITS   = 4;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        WRITE,
        WDONE
    } state_t;

    // Tag is what remains above the line index and the two byte-offset bits.
    function automatic int unsigned tag_width(int unsigned dw, int unsigned sb);
        return dw - sb - 2;
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// Backing-memory req/ack bus between the data cache (master) and data memory (slave).
interface data_cache_if
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic                  mem_byte_op_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wd_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_rd_i;

    modport master (
        output mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o,
        input  mem_ack_i, mem_rd_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o,
        output mem_ack_i, mem_rd_i
    );
endinterface

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: asynchronous read port, synchronous write port with byte merge.
module data_cache_array
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SET_BITS   = DEF_SET_BITS
) (
    input  logic                                        clk,
    input  logic                                        rst_i,
    input  logic [SET_BITS-1:0]                         idx_i,
    output logic                                        valid_o,
    output logic [tag_width(DATA_WIDTH, SET_BITS)-1:0]  tag_o,
    output logic [DATA_WIDTH-1:0]                       data_o,
    input  logic                                        wr_en_i,
    input  logic                                        wr_byte_i,
    input  logic [1:0]                                  wr_lane_i,
    input  logic [tag_width(DATA_WIDTH, SET_BITS)-1:0]  wr_tag_i,
    input  logic [DATA_WIDTH-1:0]                       wr_data_i
);
    localparam int unsigned TAG_W = tag_width(DATA_WIDTH, SET_BITS);
    localparam int unsigned LINES = 1 << SET_BITS;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

    // Byte writes only happen on a hit, so valid and tag are already correct.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            if (wr_byte_i) begin
                data_q[idx_i][{wr_lane_i, 3'b000} +: 8] <= wr_data_i[7:0];
            end else begin
                valid_q[idx_i] <= 1'b1;
                tag_q[idx_i]   <= wr_tag_i;
                data_q[idx_i]  <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the memory stage and data memory.
module data_cache
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SET_BITS   = DEF_SET_BITS
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  re_i,
    input  logic                  we_i,
    input  logic                  byte_op_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  stall_o,
    data_cache_if.master          mem,
    output logic [DATA_WIDTH-1:0] hit_count_o,
    output logic [DATA_WIDTH-1:0] miss_count_o
);
    localparam int unsigned TAG_W = tag_width(DATA_WIDTH, SET_BITS);

    state_t                state;
    logic                  mem_req_q, mem_we_q, mem_byte_q;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_wd_q;
    logic                  refilled;
    logic [DATA_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

    logic [SET_BITS-1:0]   idx;
    logic [TAG_W-1:0]      tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  hit, ack, read_hit, wr_en;

    assign idx = addr_i[SET_BITS+1:2];
    assign tag = addr_i[DATA_WIDTH-1:SET_BITS+2];
    assign hit = line_valid && (line_tag == tag);
    // An ack only counts while a request is actually outstanding.
    assign ack = mem.mem_ack_i && mem_req_q;
    assign read_hit = !rst_i && (state == IDLE) && re_i && !we_i && hit;
    assign wr_en = ack && ((state == MISS) || ((state == WRITE) && hit));

    data_cache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .SET_BITS   (SET_BITS)
    ) u_array (
        .clk       (clk),
        .rst_i     (rst_i),
        .idx_i     (idx),
        .valid_o   (line_valid),
        .tag_o     (line_tag),
        .data_o    (line_data),
        .wr_en_i   (wr_en),
        .wr_byte_i ((state == WRITE) && byte_op_i),
        .wr_lane_i (addr_i[1:0]),
        .wr_tag_i  (tag),
        .wr_data_i ((state == MISS) ? mem.mem_rd_i : wd_i)
    );

    always_comb begin
        rd_o = '0;
        if (read_hit) begin
            rd_o = byte_op_i ? {{(DATA_WIDTH-8){1'b0}}, line_data[{addr_i[1:0], 3'b000} +: 8]}
                             : line_data;
        end
    end

    always_comb begin
        stall_o = 1'b0;
        if (!rst_i) begin
            unique case (state)
                IDLE:        stall_o = we_i || (re_i && !hit);
                MISS, WRITE: stall_o = 1'b1;
                default:     stall_o = 1'b0;
            endcase
        end
    end

    // Registered bus outputs are forced low while reset is asserted.
    assign mem.mem_req_o     = mem_req_q  && !rst_i;
    assign mem.mem_we_o      = mem_we_q   && !rst_i;
    assign mem.mem_byte_op_o = mem_byte_q && !rst_i;
    assign mem.mem_addr_o    = rst_i ? '0 : mem_addr_q;
    assign mem.mem_wd_o      = rst_i ? '0 : mem_wd_q;
    assign hit_count_o       = hit_cnt_q;
    assign miss_count_o      = miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_byte_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            refilled   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    refilled <= 1'b0;
                    if (we_i) begin
                        state      <= WRITE;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_byte_q <= byte_op_i;
                        mem_addr_q <= addr_i;
                        mem_wd_q   <= wd_i;
                    end else if (re_i) begin
                        if (hit) begin
                            if (!refilled) hit_cnt_q <= hit_cnt_q + DATA_WIDTH'(1);
                        end else begin
                            miss_cnt_q <= miss_cnt_q + DATA_WIDTH'(1);
                            state      <= MISS;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_byte_q <= 1'b0;
                            mem_addr_q <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                            mem_wd_q   <= '0;
                        end
                    end
                end
                MISS: begin
                    if (ack) begin
                        mem_req_q <= 1'b0;
                        refilled  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                WRITE: begin
                    if (ack) begin
                        mem_req_q <= 1'b0;
                        state     <= WDONE;
                    end
                end
                WDONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed and randomized checks of data_cache against a word-level memory and residency model.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0, we = 1'b0, byte_op = 1'b0;
    logic [31:0] addr = '0, wd = '0;
    logic [31:0] rd, hit_cnt, miss_cnt;
    logic        stall;

    data_cache_if #(.DATA_WIDTH(32)) mem_bus ();

    data_cache #(.DATA_WIDTH(32), .SET_BITS(4)) dut (
        .clk          (clk),
        .rst_i        (rst),
        .re_i         (re),
        .we_i         (we),
        .byte_op_i    (byte_op),
        .addr_i       (addr),
        .wd_i         (wd),
        .rd_o         (rd),
        .stall_o      (stall),
        .mem          (mem_bus.master),
        .hit_count_o  (hit_cnt),
        .miss_count_o (miss_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model: backing memory by word address, plus which word address each line holds.
    logic [31:0] bmem [logic [31:0]];
    bit          m_valid [16];
    logic [29:0] m_line  [16];
    logic [31:0] m_hits = '0, m_misses = '0;

    function automatic logic [31:0] bmem_rd(input logic [31:0] wa);
        if (bmem.exists(wa)) return bmem[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic bo);
        logic [31:0] w = bmem_rd({a[31:2], 2'b00});
        if (bo) return (w >> (int'(a[1:0]) * 8)) & 32'hFF;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts();
        chk("hit_count", hit_cnt, m_hits);
        chk("miss_count", miss_cnt, m_misses);
    endtask

    task automatic do_load(input logic [31:0] a, input logic bo, input int unsigned dly,
                           output logic [31:0] got);
        logic [31:0] wa = {a[31:2], 2'b00};
        bit exp_hit = m_valid[a[5:2]] && (m_line[a[5:2]] == a[31:2]);
        re = 1'b1; we = 1'b0; byte_op = bo; addr = a;
        #1;
        if (exp_hit) begin
            chk("hit_stall", 32'(stall), 32'd0);
            chk("hit_rd", rd, exp_rd(a, bo));
            got = rd;
            m_hits++;
            step();
        end else begin
            chk("miss_stall_idle", 32'(stall), 32'd1);
            chk("miss_rd_zero", rd, 32'd0);
            m_misses++;
            step();
            for (int unsigned n = 1; n <= dly; n++) begin
                if (n == dly) begin
                    mem_bus.mem_ack_i = 1'b1;
                    mem_bus.mem_rd_i  = bmem_rd(wa);
                end
                #1;
                chk("miss_stall", 32'(stall), 32'd1);
                chk("miss_req", 32'(mem_bus.mem_req_o), 32'd1);
                chk("miss_we", 32'(mem_bus.mem_we_o), 32'd0);
                chk("miss_addr", mem_bus.mem_addr_o, wa);
                step();
                mem_bus.mem_ack_i = 1'b0;
            end
            #1;
            chk("retry_stall", 32'(stall), 32'd0);
            chk("retry_req", 32'(mem_bus.mem_req_o), 32'd0);
            chk("retry_rd", rd, exp_rd(a, bo));
            got = rd;
            m_valid[a[5:2]] = 1'b1;
            m_line[a[5:2]]  = a[31:2];
            step();
        end
        re = 1'b0;
        #1;
        chk_counts();
    endtask

    task automatic do_store(input logic [31:0] a, input logic bo, input logic [31:0] d,
                            input int unsigned dly);
        logic [31:0] wa = {a[31:2], 2'b00};
        logic [31:0] w;
        re = 1'($urandom % 2); we = 1'b1; byte_op = bo; addr = a; wd = d;
        #1;
        chk("st_stall_idle", 32'(stall), 32'd1);
        step();
        for (int unsigned n = 1; n <= dly; n++) begin
            if (n == dly) mem_bus.mem_ack_i = 1'b1;
            #1;
            chk("st_stall", 32'(stall), 32'd1);
            chk("st_req", 32'(mem_bus.mem_req_o), 32'd1);
            chk("st_we", 32'(mem_bus.mem_we_o), 32'd1);
            chk("st_byte", 32'(mem_bus.mem_byte_op_o), 32'(bo));
            chk("st_addr", mem_bus.mem_addr_o, a);
            chk("st_wd", mem_bus.mem_wd_o, d);
            step();
            mem_bus.mem_ack_i = 1'b0;
        end
        #1;
        chk("wdone_stall", 32'(stall), 32'd0);
        chk("wdone_req", 32'(mem_bus.mem_req_o), 32'd0);
        chk("wdone_rd", rd, 32'd0);
        step();
        we = 1'b0; re = 1'b0;
        w = bmem_rd(wa);
        if (bo) w[int'(a[1:0]) * 8 +: 8] = d[7:0];
        else    w = d;
        bmem[wa] = w;
        #1;
        chk_counts();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = '0;
        m_misses = '0;
    endtask

    logic [31:0] got;

    initial begin
        mem_bus.mem_ack_i = 1'b0;
        mem_bus.mem_rd_i  = '0;
        model_reset();
        bmem[32'h100] = 32'hDEAD_BEEF;
        bmem[32'h140] = 32'hCAFE_F00D;

        // Reset state
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_bus.mem_req_o), 32'd0);
        chk("rst_rd", rd, 32'd0);
        step();
        step();
        chk("rst_addr", mem_bus.mem_addr_o, 32'd0);
        chk("rst_wd", mem_bus.mem_wd_o, 32'd0);
        chk_counts();
        rst = 1'b0;
        #1;
        chk("post_rst_req", 32'(mem_bus.mem_req_o), 32'd0);
        chk("post_rst_we", 32'(mem_bus.mem_we_o), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);
        step();

        // Miss with ack on third MISS cycle, then hit, then byte hit
        do_load(32'h100, 1'b0, 3, got);
        chk("fill_data", got, 32'hDEAD_BEEF);
        chk("fill_miss_cnt", miss_cnt, 32'd1);
        chk("fill_hit_cnt", hit_cnt, 32'd0);
        do_load(32'h100, 1'b0, 1, got);
        chk("rehit_hit_cnt", hit_cnt, 32'd1);
        do_load(32'h103, 1'b1, 1, got);
        chk("byte_load", got, 32'h0000_00DE);

        // Store byte hit, then word reload
        do_store(32'h101, 1'b1, 32'h1234_56AA, 2);
        do_load(32'h100, 1'b0, 1, got);
        chk("store_merge", got, 32'hDEAD_AAEF);

        // Conflict on index 0
        do_load(32'h140, 1'b0, 1, got);
        chk("conflict_data", got, 32'hCAFE_F00D);
        do_load(32'h100, 1'b0, 2, got);
        chk("conflict_miss_cnt", miss_cnt, 32'd3);

        // Store miss does not allocate
        do_store(32'h200, 1'b0, 32'h0000_0055, 1);
        do_load(32'h200, 1'b0, 2, got);
        chk("no_alloc_data", got, 32'h0000_0055);
        chk("no_alloc_miss_cnt", miss_cnt, 32'd4);

        // Reset in the middle of a miss, with a late ack afterwards
        re = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 32'h100;
        #1;
        chk("mid_miss_stall", 32'(stall), 32'd1);
        step();
        #1;
        chk("mid_miss_req", 32'(mem_bus.mem_req_o), 32'd1);
        step();
        rst = 1'b1; re = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_bus.mem_req_o), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_addr", mem_bus.mem_addr_o, 32'd0);
        step();
        rst = 1'b0;
        mem_bus.mem_ack_i = 1'b1;
        mem_bus.mem_rd_i  = 32'h1234_5678;
        #1;
        chk("late_ack_req", 32'(mem_bus.mem_req_o), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        step();
        mem_bus.mem_ack_i = 1'b0;
        model_reset();
        #1;
        chk_counts();
        do_load(32'h100, 1'b0, 1, got);
        chk("post_rst_reload_miss", miss_cnt, 32'd1);
        chk("post_rst_reload", got, 32'hDEAD_AAEF);

        // Randomized mix of loads and stores
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a = 32'($urandom_range(0, 32'h1FF));
            logic        bo = 1'($urandom % 2);
            int unsigned dly = $urandom_range(1, 4);
            if (!bo) a[1:0] = 2'b00;
            if ($urandom_range(0, 2) == 0) do_store(a, bo, $urandom, dly);
            else                           do_load(a, bo, dly, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the CPU memory stage and the backing data memory, which replaces the single-cycle memory.
- Serves word loads and zero-extended byte loads in one cycle on a hit.
- Raises `stall_o` to the hazard unit on misses and on stores, and talks to backing memory over a req/ack handshake.

Parameters:
- DATA_WIDTH, 32, width of address, data and counters.
- SET_BITS, 4, log2 of line count; lines are one word each.

Ports:
- clk  in  1  clock
- rst_i  in  1  synchronous active-high reset
- re_i  in  1  load request from the memory stage
- we_i  in  1  store request from the memory stage
- byte_op_i  in  1  1 = byte access, 0 = word access
- addr_i  in  DATA_WIDTH  byte address
- wd_i  in  DATA_WIDTH  store data; the byte is in bits [7:0]
- rd_o  out  DATA_WIDTH  load data
- stall_o  out  1  request cannot retire this cycle
- mem_req_o  out  1  backing memory request
- mem_we_o  out  1  backing memory write
- mem_byte_op_o  out  1  byte write to backing memory
- mem_addr_o  out  DATA_WIDTH  backing memory address
- mem_wd_o  out  DATA_WIDTH  backing memory write data
- mem_ack_i  in  1  backing memory accepted the write or returned data
- mem_rd_i  in  DATA_WIDTH  word returned on a read ack
- hit_count_o  out  DATA_WIDTH  retired read hits
- miss_count_o  out  DATA_WIDTH  read misses

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_i` is synchronous and active-high.
- Address fields: index = addr[SET_BITS+1:2]; tag = addr[DATA_WIDTH-1:SET_BITS+2]. A hit requires valid and tag equal.
- Load data:
  - Word load: rd_o = line word.
  - Byte load: rd_o = zero-extended byte lane addr[1:0], little-endian.
  - rd_o is 0 whenever no read hit retires.
- States: IDLE, MISS, WRITE, WDONE. Reset state is IDLE.
- IDLE:
  - we_i=1 → stall_o=1, go to WRITE. Write wins if re_i and we_i are both high.
  - re_i=1 and hit → stall_o=0, rd_o valid combinationally. hit_count increments unless `refilled` is set.
  - re_i=1 and miss → stall_o=1, miss_count increments, go to MISS.
  - No request → stall_o=0.
  - `refilled` clears every IDLE cycle.
- MISS:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={addr[31:2],2'b00}, stall_o=1.
  - On mem_ack_i: write {valid, tag, mem_rd_i} into the line, set `refilled`, go to IDLE.
  - The retried lookup then hits with stall_o=0.
- WRITE:
  - mem_req_o=1, mem_we_o=1, mem_byte_op_o=byte_op_i, mem_addr_o=addr_i, mem_wd_o=wd_i, stall_o=1.
  - On mem_ack_i: if the line hits, update it. Word writes replace the line; byte writes merge wd_i[7:0] into lane addr[1:0].
  - A store miss does not allocate. Go to WDONE.
- WDONE: stall_o=0 for exactly one cycle so the store retires, then go to IDLE. No new request is accepted in this cycle.
- Handshake rules:
  - All mem_* outputs are held stable from req assertion until the ack cycle.
  - mem_req_o falls the cycle after ack.
  - mem_ack_i is ignored when mem_req_o=0.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss with ack after N≥1 MISS cycles: stall for 1+N cycles; data appears on the following cycle.
  - Store with ack after N cycles: stall for 1+N cycles; retires in WDONE.
- Counters wrap modulo 2^DATA_WIDTH.
- Reset: takes effect in any state, including mid-handshake.
  - State → IDLE; all valid bits, `refilled` and both counters → 0.
  - stall_o, mem_req_o, mem_we_o and mem_byte_op_o are 0 during reset and on the next cycle.
  - mem_addr_o, mem_wd_o and rd_o are 0.
  - A late ack after reset is ignored.

Decomposition:
- Package `cache_pkg`: state enum (IDLE, MISS, WRITE, WDONE) and localparams deriving index and tag widths from SET_BITS.
- Sub-module `data_cache_array`: valid/tag/data storage with one asynchronous read port and one synchronous write port carrying a byte-merge enable. Valid bits clear on rst_i.
- The top level holds the FSM, counters and mem_* interface.

Test Plan:
- Read miss then hit:
  - Stimulus: after reset, load word 0x100; backing word is 0xDEADBEEF; ack arrives on the 3rd MISS cycle.
  - Response: stall_o=1 for 4 cycles, then rd_o=0xDEADBEEF with stall_o=0; miss_count=1, hit_count=0.
  - Repeat the load: stall_o=0 in the same cycle, hit_count=1.
- Byte load: load byte 0x103 after the fill → rd_o=0x000000DE, stall_o=0.
- Store hit:
  - Stimulus: store byte 0xAA to 0x101.
  - Response: mem_req/we/byte_op=1 and mem_addr_o=0x101 held until ack; WDONE gives one cycle of stall_o=0.
  - Then load word 0x100 → hit, rd_o=0xDEADAAEF.
- Conflict: load 0x100, then 0x140 (same index 0, different tag) → both miss. Reloading 0x100 misses again; miss_count=3.
- No-allocate: store word 0x55 to 0x200 (miss), then load 0x200 → miss, and data comes from backing memory.
- Reset mid-miss:
  - Stimulus: assert rst_i during MISS before ack, and ack the cycle after.
  - Response: mem_req_o=0; the ack is ignored; counters=0; load 0x100 misses.
